// File: rtl/elevator_request_scheduler_if.sv
// Button-panel / floor-controller signal bundle seen by the request scheduler.
// The master side drives buttons and controller status; the slave side is the scheduler.
interface elevator_request_scheduler_if;
    logic [3:0] button;
    logic [1:0] current_floor;
    logic       door_open;
    logic       move_up;
    logic       move_down;
    logic [3:0] floor_request;
    logic [3:0] call_lamp;
    logic       dir_up;
    logic       busy;

    modport master (
        output button, current_floor, door_open, move_up, move_down,
        input  floor_request, call_lamp, dir_up, busy
    );

    modport slave (
        input  button, current_floor, door_open, move_up, move_down,
        output floor_request, call_lamp, dir_up, busy
    );
endinterface

// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler: latches floor calls, issues one-hot targets to the floor
// controller, clears a call when the door opens at its floor, then dwells before moving on.
module elevator_request_scheduler #(
    parameter int DOOR_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    elevator_request_scheduler_if.slave   bus
);
    localparam int CW = 4;

    typedef enum logic [1:0] {S_IDLE, S_SERVE, S_DOOR} state_t;

    typedef struct packed {
        logic       vld;
        logic       dir;
        logic [1:0] flr;
    } pick_t;

    state_t          r_state;
    logic [3:0]      r_pending;
    logic [3:0]      r_floor_request;
    logic            r_dir_up;
    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_served;

    state_t          w_state_nxt;
    logic [3:0]      w_pend_nxt;
    logic [3:0]      w_freq_nxt;
    logic            w_dir_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [1:0]      w_served_nxt;
    logic [3:0]      w_clr;
    logic            w_any_above;
    logic            w_idle_dir;
    pick_t           w_pick_run;
    pick_t           w_pick_idle;
    logic            w_unused_motion;

    // Motion flags are status only; nothing here decides on them.
    assign w_unused_motion = bus.move_up | bus.move_down;

    // Preferred direction first; if it has nothing, flip and take the other side.
    function automatic pick_t f_pick(input logic [3:0] p, input logic [1:0] cf, input logic dir);
        pick_t      r;
        logic       up_ok;
        logic       dn_ok;
        logic [1:0] up_f;
        logic [1:0] dn_f;
        up_ok = 1'b0;
        dn_ok = 1'b0;
        up_f  = 2'd0;
        dn_f  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (p[i] && (i >= int'(cf))) begin
                up_ok = 1'b1;
                up_f  = i[1:0];
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (p[i] && (i <= int'(cf))) begin
                dn_ok = 1'b1;
                dn_f  = i[1:0];
            end
        end
        r.vld = up_ok | dn_ok;
        r.dir = dir;
        r.flr = 2'd0;
        if (dir && up_ok) begin
            r.flr = up_f;
        end else if (!dir && dn_ok) begin
            r.flr = dn_f;
        end else if (up_ok) begin
            r.flr = up_f;
            r.dir = 1'b1;
        end else if (dn_ok) begin
            r.flr = dn_f;
            r.dir = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [3:0] f_onehot(input logic [1:0] f);
        return 4'b0001 << f;
    endfunction

    always_comb begin
        w_any_above = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_pending[i] && (i > int'(bus.current_floor))) w_any_above = 1'b1;
        end
    end

    // Leaving IDLE: a call at the current floor keeps the old preference.
    assign w_idle_dir  = r_pending[bus.current_floor] ? r_dir_up : w_any_above;
    assign w_pick_run  = f_pick(r_pending, bus.current_floor, r_dir_up);
    assign w_pick_idle = f_pick(r_pending, bus.current_floor, w_idle_dir);

    always_comb begin
        w_state_nxt  = r_state;
        w_freq_nxt   = r_floor_request;
        w_dir_nxt    = r_dir_up;
        w_cnt_nxt    = r_cnt;
        w_served_nxt = r_served;
        w_clr        = 4'b0000;
        case (r_state)
            S_IDLE: begin
                w_freq_nxt = 4'b0000;
                if (w_pick_idle.vld) begin
                    w_state_nxt = S_SERVE;
                    w_freq_nxt  = f_onehot(w_pick_idle.flr);
                    w_dir_nxt   = w_pick_idle.dir;
                end
            end
            S_SERVE: begin
                if (!w_pick_run.vld) begin
                    w_state_nxt = S_IDLE;
                    w_freq_nxt  = 4'b0000;
                end else if (bus.door_open && (bus.current_floor == w_pick_run.flr)) begin
                    w_clr        = f_onehot(bus.current_floor);
                    w_served_nxt = bus.current_floor;
                    w_cnt_nxt    = CW'(DOOR_CYCLES - 1);
                    w_state_nxt  = S_DOOR;
                    w_freq_nxt   = f_onehot(bus.current_floor);
                    w_dir_nxt    = w_pick_run.dir;
                end else begin
                    w_freq_nxt = f_onehot(w_pick_run.flr);
                    w_dir_nxt  = w_pick_run.dir;
                end
            end
            S_DOOR: begin
                w_freq_nxt = f_onehot(r_served);
                if (r_cnt == '0) begin
                    if (w_pick_run.vld) begin
                        w_state_nxt = S_SERVE;
                        w_freq_nxt  = f_onehot(w_pick_run.flr);
                        w_dir_nxt   = w_pick_run.dir;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_freq_nxt  = 4'b0000;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_freq_nxt  = 4'b0000;
            end
        endcase
    end

    // Clear beats a same-cycle press; a held button re-arms the call next cycle.
    assign w_pend_nxt = (r_pending | bus.button) & ~w_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_pending       <= 4'b0000;
            r_floor_request <= 4'b0000;
            r_dir_up        <= 1'b1;
            r_busy          <= 1'b0;
            r_cnt           <= '0;
            r_served        <= 2'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_pending       <= w_pend_nxt;
            r_floor_request <= w_freq_nxt;
            r_dir_up        <= w_dir_nxt;
            r_busy          <= (w_state_nxt != S_IDLE);
            r_cnt           <= w_cnt_nxt;
            r_served        <= w_served_nxt;
        end
    end

    assign bus.floor_request = r_floor_request;
    assign bus.call_lamp     = r_pending;
    assign bus.dir_up        = r_dir_up;
    assign bus.busy          = r_busy;
endmodule
